// File: rtl/ddr_bank_fsm.sv
// Per-bank DRAM controller: turns router requests into ACT/RD/WR/PRE/REF.
// Build option: define OPEN_PAGE_EN to keep rows open after column access.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 4
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 4
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 4
`endif

module ddr_bank_fsm #(
    parameter int BANK_ID = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [`AXI_ID_WIDTH-1:0]  req_id,
    input  logic [`DRAM_RA_WIDTH-1:0] req_ra,
    input  logic [`DRAM_CA_WIDTH-1:0] req_ca,
    input  logic                      req_wr,
    input  logic [`T_RCD_WIDTH-1:0]   t_rcd_m1,
    input  logic [`T_RP_WIDTH-1:0]    t_rp_m1,
    input  logic [`T_RAS_WIDTH-1:0]   t_ras_m1,
    input  logic [`T_RFC_WIDTH-1:0]   t_rfc_m1,
    input  logic [`T_RTP_WIDTH-1:0]   t_rtp_m1,
    input  logic [`T_WTP_WIDTH-1:0]   t_wtp_m1,
    input  logic                      ref_pending,
    output logic                      act_req,
    output logic                      rd_req,
    output logic                      wr_req,
    output logic                      pre_req,
    output logic                      ref_req,
    input  logic                      act_gnt,
    input  logic                      rd_gnt,
    input  logic                      wr_gnt,
    input  logic                      pre_gnt,
    input  logic                      ref_gnt,
    output logic [`DRAM_BA_WIDTH-1:0] sched_ba,
    output logic [`DRAM_RA_WIDTH-1:0] sched_ra,
    output logic [`DRAM_CA_WIDTH-1:0] sched_ca,
    output logic [`AXI_ID_WIDTH-1:0]  cur_id
);

    localparam int C2P_W = (`T_RTP_WIDTH > `T_WTP_WIDTH) ?
                           `T_RTP_WIDTH : `T_WTP_WIDTH;

    typedef enum logic [2:0] {
        CLOSED,
        ACTIVATING,
        OPEN,
        PRECHARGING,
        REFRESHING
    } state_t;

    state_t state, st_mid, state_n;

    logic [`T_RCD_WIDTH-1:0]   rcd, rcd_n;
    logic [`T_RP_WIDTH-1:0]    rp, rp_n;
    logic [`T_RAS_WIDTH-1:0]   ras, ras_n;
    logic [`T_RFC_WIDTH-1:0]   rfc, rfc_n;
    logic [C2P_W-1:0]          c2p, c2p_n;
    logic [`DRAM_RA_WIDTH-1:0] open_row, open_row_n;
    logic                      close_pend, close_pend_n;

    logic act_fire, rd_fire, wr_fire, pre_fire, ref_fire, col_fire;
    logic vld, hit, hold;
    logic act_n, rd_n, wr_n, pre_n, ref_n;
    logic [`DRAM_RA_WIDTH-1:0] ra_n;
    logic [`DRAM_CA_WIDTH-1:0] ca_n;
    logic [`AXI_ID_WIDTH-1:0]  id_n;

    // Grants count only against the request currently raised.
    assign act_fire = act_req & act_gnt;
    assign rd_fire  = rd_req & rd_gnt;
    assign wr_fire  = wr_req & wr_gnt;
    assign pre_fire = pre_req & pre_gnt;
    assign ref_fire = ref_req & ref_gnt;
    assign col_fire = rd_fire | wr_fire;

    assign req_ready = col_fire;
    assign sched_ba  = `DRAM_BA_WIDTH'(BANK_ID);

    always_comb begin
        rcd_n = (rcd != '0) ? rcd - `T_RCD_WIDTH'(1) : rcd;
        rp_n  = (rp  != '0) ? rp  - `T_RP_WIDTH'(1)  : rp;
        ras_n = (ras != '0) ? ras - `T_RAS_WIDTH'(1) : ras;
        rfc_n = (rfc != '0) ? rfc - `T_RFC_WIDTH'(1) : rfc;
        c2p_n = (c2p != '0) ? c2p - C2P_W'(1)        : c2p;
        st_mid       = state;
        open_row_n   = open_row;
        close_pend_n = close_pend;

        if (act_fire) begin
            st_mid     = ACTIVATING;
            open_row_n = sched_ra;
            rcd_n      = t_rcd_m1;
            ras_n      = t_ras_m1;
        end
        if (col_fire) begin
            c2p_n = rd_fire ? C2P_W'(t_rtp_m1) : C2P_W'(t_wtp_m1);
`ifndef OPEN_PAGE_EN
            close_pend_n = 1'b1;
`endif
        end
        if (pre_fire) begin
            st_mid       = PRECHARGING;
            rp_n         = t_rp_m1;
            close_pend_n = 1'b0;
        end
        if (ref_fire) begin
            st_mid = REFRESHING;
            rfc_n  = t_rfc_m1;
        end

        // Waiting states fall through as soon as their timer expires.
        state_n = st_mid;
        unique case (st_mid)
            ACTIVATING:  if (rcd_n == '0) state_n = OPEN;
            PRECHARGING: if (rp_n == '0)  state_n = CLOSED;
            REFRESHING:  if (rfc_n == '0) state_n = CLOSED;
            default:     state_n = st_mid;
        endcase

        // Look ahead so the registered requests appear on the first legal cycle.
        vld  = req_valid & ~col_fire;
        hit  = (req_ra == open_row_n);
        hold = (act_req & ~act_gnt) | (rd_req & ~rd_gnt) |
               (wr_req & ~wr_gnt) | (pre_req & ~pre_gnt) |
               (ref_req & ~ref_gnt);
        act_n = 1'b0;
        rd_n  = 1'b0;
        wr_n  = 1'b0;
        pre_n = 1'b0;
        ref_n = 1'b0;
        ra_n  = sched_ra;
        ca_n  = sched_ca;
        id_n  = cur_id;

        if (hold) begin
            act_n = act_req;
            rd_n  = rd_req;
            wr_n  = wr_req;
            pre_n = pre_req;
            ref_n = ref_req;
        end else begin
            unique case (state_n)
                CLOSED: begin
                    if (ref_pending) begin
                        ref_n = 1'b1;
                    end else if (vld) begin
                        act_n = 1'b1;
                        ra_n  = req_ra;
                        id_n  = req_id;
                    end
                end
                OPEN: begin
                    if (vld & hit & ~ref_pending & ~close_pend_n) begin
                        rd_n = ~req_wr;
                        wr_n = req_wr;
                        ca_n = req_ca;
                        id_n = req_id;
                    end else if ((ras_n == '0) && (c2p_n == '0) &&
                                 (close_pend_n | ref_pending |
                                  (vld & ~hit))) begin
                        pre_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLOSED;
            rcd        <= '0;
            rp         <= '0;
            ras        <= '0;
            rfc        <= '0;
            c2p        <= '0;
            open_row   <= '0;
            close_pend <= 1'b0;
            act_req    <= 1'b0;
            rd_req     <= 1'b0;
            wr_req     <= 1'b0;
            pre_req    <= 1'b0;
            ref_req    <= 1'b0;
            sched_ra   <= '0;
            sched_ca   <= '0;
            cur_id     <= '0;
        end else begin
            state      <= state_n;
            rcd        <= rcd_n;
            rp         <= rp_n;
            ras        <= ras_n;
            rfc        <= rfc_n;
            c2p        <= c2p_n;
            open_row   <= open_row_n;
            close_pend <= close_pend_n;
            act_req    <= act_n;
            rd_req     <= rd_n;
            wr_req     <= wr_n;
            pre_req    <= pre_n;
            ref_req    <= ref_n;
            sched_ra   <= ra_n;
            sched_ca   <= ca_n;
            cur_id     <= id_n;
        end
    end

`ifndef SYNTHESIS
    a_act_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        act_gnt |-> act_req);
    a_rd_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        rd_gnt |-> rd_req);
    a_wr_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        wr_gnt |-> wr_req);
    a_pre_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        pre_gnt |-> pre_req);
    a_ref_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        ref_gnt |-> ref_req);
    a_onehot: assert property (@(posedge clk)
        $onehot0({act_req, rd_req, wr_req, pre_req, ref_req}));
`endif

endmodule

// File: tb/tb_ddr_bank_fsm.sv
// Directed bench for ddr_bank_fsm with same-cycle scheduler grants.
// Open-page scenarios are built when OPEN_PAGE_EN is defined.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 14
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif
`ifndef T_RCD_WIDTH
`define T_RCD_WIDTH 4
`endif
`ifndef T_RP_WIDTH
`define T_RP_WIDTH 4
`endif
`ifndef T_RAS_WIDTH
`define T_RAS_WIDTH 6
`endif
`ifndef T_RFC_WIDTH
`define T_RFC_WIDTH 8
`endif
`ifndef T_RTP_WIDTH
`define T_RTP_WIDTH 4
`endif
`ifndef T_WTP_WIDTH
`define T_WTP_WIDTH 4
`endif

module tb_ddr_bank_fsm;

    logic clk = 1'b0;
    logic rst_n;
    logic req_valid;
    logic req_ready;
    logic [`AXI_ID_WIDTH-1:0]  req_id;
    logic [`DRAM_RA_WIDTH-1:0] req_ra;
    logic [`DRAM_CA_WIDTH-1:0] req_ca;
    logic req_wr;
    logic ref_pending;
    logic act_req, rd_req, wr_req, pre_req, ref_req;
    logic act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic [`DRAM_BA_WIDTH-1:0] sched_ba;
    logic [`DRAM_RA_WIDTH-1:0] sched_ra;
    logic [`DRAM_CA_WIDTH-1:0] sched_ca;
    logic [`AXI_ID_WIDTH-1:0]  cur_id;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_act = 0;
    int n_pre = 0;

    always #5 clk = ~clk;

    assign act_gnt = act_req;
    assign rd_gnt  = rd_req;
    assign wr_gnt  = wr_req;
    assign pre_gnt = pre_req;
    assign ref_gnt = ref_req;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (act_req & act_gnt) n_act <= n_act + 1;
        if (pre_req & pre_gnt) n_pre <= n_pre + 1;
    end

    ddr_bank_fsm #(.BANK_ID(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_id(req_id), .req_ra(req_ra),
        .req_ca(req_ca), .req_wr(req_wr),
        .t_rcd_m1(`T_RCD_WIDTH'(2)), .t_rp_m1(`T_RP_WIDTH'(2)),
        .t_ras_m1(`T_RAS_WIDTH'(5)), .t_rfc_m1(`T_RFC_WIDTH'(9)),
        .t_rtp_m1(`T_RTP_WIDTH'(2)), .t_wtp_m1(`T_WTP_WIDTH'(2)),
        .ref_pending(ref_pending),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
        .pre_req(pre_req), .ref_req(ref_req),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .sched_ba(sched_ba), .sched_ra(sched_ra),
        .sched_ca(sched_ca), .cur_id(cur_id)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic drive(input logic v, input int ra, input int ca,
                         input int id, input logic wr);
        req_valid = v;
        req_ra    = `DRAM_RA_WIDTH'(ra);
        req_ca    = `DRAM_CA_WIDTH'(ca);
        req_id    = `AXI_ID_WIDTH'(id);
        req_wr    = wr;
    endtask

    function automatic logic sel(input int which);
        case (which)
            0: sel = act_req;
            1: sel = rd_req;
            2: sel = wr_req;
            3: sel = pre_req;
            default: sel = ref_req;
        endcase
    endfunction

    task automatic wait_req(input string tag, input int which,
                            output int t);
        t = -1;
        for (int k = 0; k < 40; k++) begin
            if (sel(which)) begin
                t = cyc;
                break;
            end
            step();
        end
        check(tag, 32'(t >= 0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ref_pending = 1'b0;
        drive(1'b0, 0, 0, 0, 1'b0);
        step(2);
        check("rst_reqs", {act_req, rd_req, wr_req, pre_req, ref_req}, 0);
        check("rst_ready", req_ready, 0);
        check("rst_ra", sched_ra, 0);
        check("rst_ca", sched_ca, 0);
        check("rst_id", cur_id, 0);
        check("rst_ba", sched_ba, 2);
        rst_n = 1'b1;
        step();
    endtask

    int t, p, a, w, r, n0, p0;

    initial begin
        // Read to a closed bank.
        do_reset();
        drive(1'b1, 'h12, 'h05, 3, 1'b0);
        wait_req("rd_act_seen", 0, t);
        check("rd_act_ra", sched_ra, 'h12);
        check("rd_act_id", cur_id, 3);
        step();
        check("rcd_t1", rd_req, 0);
        step();
        check("rcd_t2", rd_req, 0);
        step();
        check("rd_t3", rd_req, 1);
        check("ready_t3", req_ready, 1);
        check("rd_ca", sched_ca, 'h05);
        check("rd_id", cur_id, 3);
        step();
        req_valid = 1'b0;
        check("ready_once", req_ready, 0);
`ifndef OPEN_PAGE_EN
        step();
        check("pre_t5", pre_req, 0);
        step();
        check("pre_t6", pre_req, 1);
        p = cyc;
        // Same row again still costs ACT+WR+PRE in closed-page mode.
        drive(1'b1, 'h12, 'h09, 5, 1'b1);
        wait_req("wr_act_seen", 0, a);
        check("act_after_rp", 32'(a - p), 3);
        step(3);
        check("wr_t3", wr_req, 1);
        check("wr_id", cur_id, 5);
        check("wr_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        check("wtp_w2", pre_req, 0);
        step();
        check("wtp_w3", pre_req, 1);
`endif

`ifdef OPEN_PAGE_EN
        // Two row hits, then a miss.
        do_reset();
        n0 = n_act;
        p0 = n_pre;
        drive(1'b1, 'h12, 'h05, 3, 1'b0);
        wait_req("hit_act_seen", 0, t);
        step(3);
        check("hit_rd1", rd_req, 1);
        step();
        drive(1'b1, 'h12, 'h07, 4, 1'b0);
        check("hit_no_act", act_req, 0);
        step();
        check("hit_rd2", rd_req, 1);
        check("hit_rd2_ca", sched_ca, 'h07);
        check("hit_rd2_id", cur_id, 4);
        check("hit_one_act", 32'(n_act - n0), 1);
        check("hit_no_pre", 32'(n_pre - p0), 0);
        step();
        drive(1'b1, 'h12, 'h0A, 6, 1'b1);
        step();
        check("miss_wr", wr_req, 1);
        w = cyc;
        step();
        drive(1'b1, 'h34, 'h02, 8, 1'b0);
        check("miss_w1", pre_req, 0);
        step();
        check("miss_w2", pre_req, 0);
        step();
        check("miss_w3", pre_req, 1);
        p = cyc;
        step(2);
        check("miss_p2", act_req, 0);
        step();
        check("miss_p3", act_req, 1);
        check("miss_ra", sched_ra, 'h34);
        step(3);
        check("miss_rd", rd_req, 1);
        check("miss_id", cur_id, 8);
        step();
        req_valid = 1'b0;
`endif

        // Refresh requested while the row is open.
        do_reset();
        drive(1'b1, 'h40, 'h01, 7, 1'b0);
        wait_req("ref_act_seen", 0, t);
        ref_pending = 1'b1;
        step(3);
        check("ref_blocks_rd", rd_req, 0);
        step(2);
        check("ref_pre_t5", pre_req, 0);
        step();
        check("ref_pre_t6", pre_req, 1);
        p = cyc;
        wait_req("ref_seen", 4, r);
        check("ref_after_rp", 32'(r - p), 3);
        ref_pending = 1'b0;
        step(9);
        check("rfc_r9", act_req, 0);
        step();
        check("rfc_r10", act_req, 1);
        check("rfc_ra", sched_ra, 'h40);
        step(3);
        check("rfc_rd", rd_req, 1);
        check("rfc_id", cur_id, 7);
        step();
        req_valid = 1'b0;

        // Reset while activating.
        do_reset();
        drive(1'b1, 'h55, 'h03, 9, 1'b0);
        wait_req("ra_act_seen", 0, t);
        step();
        rst_n = 1'b0;
        step();
        check("ra_reqs", {act_req, rd_req, wr_req, pre_req, ref_req}, 0);
        check("ra_id", cur_id, 0);
        check("ra_ra", sched_ra, 0);
        rst_n = 1'b1;
        wait_req("ra_act2_seen", 0, a);
        check("ra_act_lat", 32'(a - t), 3);
        check("ra_act2_ra", sched_ra, 'h55);
        step(3);
        check("ra_rd", rd_req, 1);
        step();
        req_valid = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
